// File: rtl/rdma_sq_arbiter_pkg.sv
// Shared RDMA types and sizes (lynxTypes) used by the SQ arbiter and its selector.
package lynxTypes;

    localparam int RDMA_REQ_BITS        = 64;
    localparam int RDMA_MAX_OUTSTANDING = 16;
    localparam int N_REGIONS            = 4;
    localparam int RDMA_ARB_CNT_BITS    = 8;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } arb_state_t;

endpackage

// File: rtl/rdma_sq_arbiter_rr_sel.sv
// Rotating-priority selector: the first eligible index at or after i_ptr wins,
// wrapping modulo N.
module rdma_rr_sel #(
    parameter int N = 4,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] i_elig,
    input  logic [W-1:0] i_ptr,
    output logic [N-1:0] o_grant,
    output logic [W-1:0] o_idx,
    output logic         o_any
);

    logic [W-1:0] w_j;

    // Scan from the farthest offset down so the nearest eligible index is written last.
    always_comb begin
        o_idx   = '0;
        o_any   = 1'b0;
        o_grant = '0;
        w_j     = '0;
        for (int k = N - 1; k >= 0; k--) begin
            w_j = i_ptr + W'(k);
            if (i_elig[w_j]) begin
                o_idx = w_j;
                o_any = 1'b1;
            end
        end
        if (o_any) begin
            o_grant[o_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/rdma_sq_arbiter.sv
// Round-robin SQ command arbiter with per-requester outstanding credits.
// Optional per-requester stats counters when RDMA_SQ_ARB_STATS_EN is defined.
module rdma_sq_arbiter
    import lynxTypes::*;
#(
    parameter int N_REQ    = N_REGIONS,
    parameter int REQ_BITS = RDMA_REQ_BITS,
    parameter int MAX_OUT  = RDMA_MAX_OUTSTANDING,
    parameter int W        = $clog2(N_REQ)
) (
    input  logic                          nclk,
    input  logic                          nreset,
    input  logic [N_REQ-1:0]              s_sq_valid,
    output logic [N_REQ-1:0]              s_sq_ready,
    input  logic [N_REQ*REQ_BITS-1:0]     s_sq_data,
    output logic                          m_sq_valid,
    input  logic                          m_sq_ready,
    output logic [REQ_BITS-1:0]           m_sq_data,
    output logic [W-1:0]                  m_sq_id,
    input  logic                          s_ack_valid,
    input  logic [W-1:0]                  s_ack_id,
    input  logic                          s_ack_nak,
    output logic [N_REQ-1:0]              nak_flag,
    output logic                          err_underflow,
    output logic [N_REQ*RDMA_ARB_CNT_BITS-1:0] out_cnt
`ifdef RDMA_SQ_ARB_STATS_EN
    ,
    output logic [N_REQ*32-1:0]           stat_issued,
    output logic [N_REQ*32-1:0]           stat_stall
`endif
);

    localparam int CB = RDMA_ARB_CNT_BITS;
    localparam logic [CB-1:0] MAX_OUT_C = CB'(MAX_OUT);

    arb_state_t          r_state;
    arb_state_t          w_state_nxt;
    logic [W-1:0]        r_rr_ptr;
    logic [REQ_BITS-1:0] r_data;
    logic [W-1:0]        r_id;
    logic [CB-1:0]       r_cnt [N_REQ];
    logic [N_REQ-1:0]    r_nak;
    logic                r_underflow;

    logic [N_REQ-1:0]    w_elig;
    logic [N_REQ-1:0]    w_grant;
    logic [W-1:0]        w_idx;
    logic                w_any;
    logic                w_accept;
    logic [REQ_BITS-1:0] w_req_data [N_REQ];

    for (genvar g = 0; g < N_REQ; g++) begin : g_req
        assign w_elig[g]                = s_sq_valid[g] && (r_cnt[g] < MAX_OUT_C);
        assign w_req_data[g]            = s_sq_data[g*REQ_BITS +: REQ_BITS];
        assign out_cnt[g*CB +: CB]      = r_cnt[g];
    end

    rdma_rr_sel #(.N(N_REQ), .W(W)) u_sel (
        .i_elig  (w_elig),
        .i_ptr   (r_rr_ptr),
        .o_grant (w_grant),
        .o_idx   (w_idx),
        .o_any   (w_any)
    );

    // A slot is free when empty, or when the held command leaves this cycle.
    assign w_accept   = w_any && ((r_state == ST_EMPTY) || m_sq_ready);
    assign s_sq_ready = w_accept ? w_grant : '0;
    assign m_sq_valid = (r_state == ST_FULL);
    assign m_sq_data  = r_data;
    assign m_sq_id    = r_id;
    assign nak_flag   = r_nak;
    assign err_underflow = r_underflow;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_EMPTY: if (w_accept) w_state_nxt = ST_FULL;
            ST_FULL:  if (m_sq_ready) w_state_nxt = w_any ? ST_FULL : ST_EMPTY;
            default:  w_state_nxt = ST_EMPTY;
        endcase
    end

    always_ff @(posedge nclk) begin
        if (nreset) begin
            r_state  <= ST_EMPTY;
            r_rr_ptr <= '0;
            r_data   <= '0;
            r_id     <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_data   <= w_req_data[w_idx];
                r_id     <= w_idx;
                r_rr_ptr <= w_idx + W'(1);
            end
        end
    end

    // A retire that coincides with an accept on the same requester nets to zero
    // and is not an underflow, since the accepted command backs it.
    always_ff @(posedge nclk) begin
        if (nreset) begin
            for (int i = 0; i < N_REQ; i++) r_cnt[i] <= '0;
            r_nak       <= '0;
            r_underflow <= 1'b0;
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                if (w_accept && (w_idx == W'(i))) begin
                    if (!(s_ack_valid && (s_ack_id == W'(i)))) begin
                        r_cnt[i] <= r_cnt[i] + CB'(1);
                    end
                end else if (s_ack_valid && (s_ack_id == W'(i))) begin
                    if (r_cnt[i] != '0) begin
                        r_cnt[i] <= r_cnt[i] - CB'(1);
                    end else begin
                        r_underflow <= 1'b1;
                    end
                end
                if (s_ack_valid && s_ack_nak && (s_ack_id == W'(i))) begin
                    r_nak[i] <= 1'b1;
                end
            end
        end
    end

`ifdef RDMA_SQ_ARB_STATS_EN
    logic [31:0] r_issued [N_REQ];
    logic [31:0] r_stall  [N_REQ];

    for (genvar g = 0; g < N_REQ; g++) begin : g_stat
        assign stat_issued[g*32 +: 32] = r_issued[g];
        assign stat_stall[g*32 +: 32]  = r_stall[g];
    end

    always_ff @(posedge nclk) begin
        if (nreset) begin
            for (int i = 0; i < N_REQ; i++) begin
                r_issued[i] <= '0;
                r_stall[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                if (w_accept && (w_idx == W'(i))) r_issued[i] <= r_issued[i] + 32'd1;
                if (s_sq_valid[i] && (r_cnt[i] == MAX_OUT_C)) r_stall[i] <= r_stall[i] + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_rdma_sq_arbiter.sv
// Directed bench for rdma_sq_arbiter: N_REQ=4, 16-bit commands, MAX_OUT=2.
module tb_rdma_sq_arbiter;

    localparam int N  = 4;
    localparam int RB = 16;

    logic          nclk = 1'b0;
    logic          nreset;
    logic [N-1:0]  s_sq_valid;
    logic [N-1:0]  s_sq_ready;
    logic [N*RB-1:0] s_sq_data;
    logic          m_sq_valid;
    logic          m_sq_ready;
    logic [RB-1:0] m_sq_data;
    logic [1:0]    m_sq_id;
    logic          s_ack_valid;
    logic [1:0]    s_ack_id;
    logic          s_ack_nak;
    logic [N-1:0]  nak_flag;
    logic          err_underflow;
    logic [N*8-1:0] out_cnt;
`ifdef RDMA_SQ_ARB_STATS_EN
    logic [N*32-1:0] stat_issued;
    logic [N*32-1:0] stat_stall;
`endif

    int n_chk = 0;
    int n_err = 0;

    always #5 nclk = ~nclk;

    rdma_sq_arbiter #(.N_REQ(N), .REQ_BITS(RB), .MAX_OUT(2)) dut (
        .nclk          (nclk),
        .nreset        (nreset),
        .s_sq_valid    (s_sq_valid),
        .s_sq_ready    (s_sq_ready),
        .s_sq_data     (s_sq_data),
        .m_sq_valid    (m_sq_valid),
        .m_sq_ready    (m_sq_ready),
        .m_sq_data     (m_sq_data),
        .m_sq_id       (m_sq_id),
        .s_ack_valid   (s_ack_valid),
        .s_ack_id      (s_ack_id),
        .s_ack_nak     (s_ack_nak),
        .nak_flag      (nak_flag),
        .err_underflow (err_underflow),
        .out_cnt       (out_cnt)
`ifdef RDMA_SQ_ARB_STATS_EN
        ,
        .stat_issued   (stat_issued),
        .stat_stall    (stat_stall)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] data_of(input int i);
        case (i)
            0:       return 32'hA000;
            1:       return 32'hA111;
            2:       return 32'hA222;
            default: return 32'hA333;
        endcase
    endfunction

    // Called just after a falling edge; retires one credit over the next rising edge.
    task automatic ack_once(input logic [1:0] id, input logic nak);
        s_ack_valid = 1'b1;
        s_ack_id    = id;
        s_ack_nak   = nak;
        @(negedge nclk);
        s_ack_valid = 1'b0;
        s_ack_nak   = 1'b0;
    endtask

    initial begin
        nreset      = 1'b1;
        s_sq_valid  = '0;
        s_sq_data   = 64'hA333_A222_A111_A000;
        m_sq_ready  = 1'b0;
        s_ack_valid = 1'b0;
        s_ack_id    = '0;
        s_ack_nak   = 1'b0;

        // reset state
        repeat (3) @(negedge nclk);
        #1;
        chk("rst_valid", 32'(m_sq_valid), 32'd0);
        chk("rst_data",  32'(m_sq_data),  32'd0);
        chk("rst_id",    32'(m_sq_id),    32'd0);
        chk("rst_ready", 32'(s_sq_ready), 32'd0);
        chk("rst_cnt",   out_cnt,         32'd0);
        chk("rst_nak",   32'(nak_flag),   32'd0);
        chk("rst_uflow", 32'(err_underflow), 32'd0);
        nreset = 1'b0;
        @(negedge nclk);

        // fairness: all valid, sink always ready
        s_sq_valid = 4'hF;
        m_sq_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            #1;
            chk("fair_ready", 32'(s_sq_ready), 32'(1 << (k % 4)));
            @(negedge nclk);
            chk("fair_id",   32'(m_sq_id),   32'(k % 4));
            chk("fair_data", 32'(m_sq_data), data_of(k % 4));
        end
        #1;
        chk("fair_capped_ready", 32'(s_sq_ready), 32'd0);
        chk("fair_cnt",          out_cnt,         32'h0202_0202);
        @(negedge nclk);
        chk("fair_drained", 32'(m_sq_valid), 32'd0);
        s_sq_valid = '0;

        // drain all credits
        for (int i = 0; i < N; i++) begin
            ack_once(2'(i), 1'b0);
            ack_once(2'(i), 1'b0);
        end
        #1;
        chk("drain_cnt",   out_cnt,                 32'd0);
        chk("drain_uflow", 32'(err_underflow),      32'd0);

        // credit cap on requester 1
        s_sq_valid = 4'b0010;
        #1 chk("cap_rdy0", 32'(s_sq_ready), 32'b0010);
        @(negedge nclk);
        #1 chk("cap_rdy1", 32'(s_sq_ready), 32'b0010);
        @(negedge nclk);
        #1;
        chk("cap_rdy2", 32'(s_sq_ready), 32'd0);
        chk("cap_cnt1", 32'(out_cnt[15:8]), 32'd2);
        chk("cap_id",   32'(m_sq_id),       32'd1);
        @(negedge nclk);
        #1 chk("cap_rdy3", 32'(s_sq_ready), 32'd0);
        s_ack_valid = 1'b1;
        s_ack_id    = 2'd1;
        #1 chk("ack_T_rdy", 32'(s_sq_ready), 32'd0);
        @(negedge nclk);
        s_ack_valid = 1'b0;
        #1 chk("ack_T1_rdy", 32'(s_sq_ready), 32'b0010);
        @(negedge nclk);
        chk("ack_reissue_cnt", 32'(out_cnt[15:8]), 32'd2);
        chk("ack_reissue_out", 32'({m_sq_valid, m_sq_id}), 32'b101);
        s_sq_valid = '0;

        // accept and retire on requester 2 in the same cycle
        s_sq_valid = 4'b0100;
        #1 chk("sim_rdy0", 32'(s_sq_ready), 32'b0100);
        @(negedge nclk);
        s_ack_valid = 1'b1;
        s_ack_id    = 2'd2;
        #1 chk("sim_rdy1", 32'(s_sq_ready), 32'b0100);
        @(negedge nclk);
        s_ack_valid = 1'b0;
        s_sq_valid  = '0;
        #1 chk("sim_cnt2", 32'(out_cnt[23:16]), 32'd1);

        // backpressure
        ack_once(2'd1, 1'b0);
        ack_once(2'd1, 1'b0);
        ack_once(2'd2, 1'b0);
        m_sq_ready = 1'b0;
        s_sq_valid = 4'b1001;
        #1 chk("bp_rdy0", 32'(s_sq_ready), 32'b1000);
        @(negedge nclk);
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("bp_hold_valid", 32'(m_sq_valid), 32'd1);
            chk("bp_hold_id",    32'(m_sq_id),    32'd3);
            chk("bp_hold_data",  32'(m_sq_data),  32'hA333);
            chk("bp_hold_ready", 32'(s_sq_ready), 32'd0);
            @(negedge nclk);
        end
        m_sq_ready = 1'b1;
        #1 chk("bp_rel_rdy0", 32'(s_sq_ready), 32'b0001);
        @(negedge nclk);
        chk("bp_rel_id0",   32'(m_sq_id),   32'd0);
        chk("bp_rel_data0", 32'(m_sq_data), 32'hA000);
        #1 chk("bp_rel_rdy1", 32'(s_sq_ready), 32'b1000);
        @(negedge nclk);
        chk("bp_rel_id1",   32'(m_sq_id),   32'd3);
        #1 chk("bp_rel_rdy2", 32'(s_sq_ready), 32'b0001);
        @(negedge nclk);
        chk("bp_rel_id2",   32'(m_sq_id),   32'd0);
        #1 chk("bp_rel_rdy3", 32'(s_sq_ready), 32'd0);
        @(negedge nclk);
        chk("bp_rel_empty", 32'(m_sq_valid), 32'd0);
        s_sq_valid = '0;

        // underflow and NAK
        ack_once(2'd3, 1'b0);
        ack_once(2'd3, 1'b0);
        #1;
        chk("uf_pre_flag", 32'(err_underflow),   32'd0);
        chk("uf_pre_cnt3", 32'(out_cnt[31:24]),  32'd0);
        ack_once(2'd3, 1'b0);
        #1;
        chk("uf_flag", 32'(err_underflow),  32'd1);
        chk("uf_cnt3", 32'(out_cnt[31:24]), 32'd0);
        ack_once(2'd0, 1'b1);
        #1;
        chk("nak_flag", 32'(nak_flag),      32'b0001);
        chk("nak_cnt0", 32'(out_cnt[7:0]),  32'd1);

        // reset while holding a command
        m_sq_ready = 1'b0;
        s_sq_valid = 4'b0010;
        @(negedge nclk);
        s_sq_valid = '0;
        #1;
        chk("rf_valid", 32'(m_sq_valid),     32'd1);
        chk("rf_cnt1",  32'(out_cnt[15:8]),  32'd1);
`ifdef RDMA_SQ_ARB_STATS_EN
        chk("stat_iss0", stat_issued[31:0],   32'd4);
        chk("stat_iss1", stat_issued[63:32],  32'd6);
        chk("stat_iss2", stat_issued[95:64],  32'd4);
        chk("stat_iss3", stat_issued[127:96], 32'd4);
`endif
        nreset = 1'b1;
        @(negedge nclk);
        #1;
        chk("rf_post_valid", 32'(m_sq_valid),    32'd0);
        chk("rf_post_data",  32'(m_sq_data),     32'd0);
        chk("rf_post_cnt",   out_cnt,            32'd0);
        chk("rf_post_nak",   32'(nak_flag),      32'd0);
        chk("rf_post_uflow", 32'(err_underflow), 32'd0);
        nreset = 1'b0;
        @(negedge nclk);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/rdma_sq_arbiter.md
# rdma_sq_arbiter

Shares the single RoCE send-queue (SQ) command port among `N_REQ` requesters (one per vFPGA region). It does round-robin arbitration, gated by per-requester outstanding-credit accounting. Credits are returned by the RX ACK/NAK metadata stream. It sits between the per-region SQ command interfaces and the RoCE stack SQ input. It replaces the single global outstanding counter with per-region accounting, so one region cannot starve the others.

## Interface
- `N_REQ`, 4: number of requesters; power of two, 2..16.
- `REQ_BITS`, `RDMA_REQ_BITS`: width of one SQ command word, passed through unmodified.
- `MAX_OUT`, `RDMA_MAX_OUTSTANDING`: per-requester outstanding-command limit; 1..255.
- `nclk`  in  1  clock; all logic on rising edge.
- `nreset`  in  1  reset; synchronous, active-high.
- `s_sq_valid`  in  N_REQ  per-requester command valid.
- `s_sq_ready`  out  N_REQ  per-requester command accept.
- `s_sq_data`  in  N_REQ×REQ_BITS  per-requester command words, packed, requester i at `[i*REQ_BITS+:REQ_BITS]`.
- `m_sq_valid`  out  1  command to RoCE stack valid.
- `m_sq_ready`  in  1  RoCE stack accept.
- `m_sq_data`  out  REQ_BITS  granted command word.
- `m_sq_id`  out  log2(N_REQ)  requester index of `m_sq_data`.
- `s_ack_valid`  in  1  ACK/NAK retire event; always accepted, with no ready signal.
- `s_ack_id`  in  log2(N_REQ)  requester the retire belongs to.
- `s_ack_nak`  in  1  retire is a NAK.
- `nak_flag`  out  N_REQ  sticky per-requester NAK seen.
- `err_underflow`  out  1  sticky: an ACK arrived for a requester with zero credit in use.
- `out_cnt`  out  N_REQ×8  per-requester outstanding count.

## Operation
- Eligibility: requester i is eligible when `s_sq_valid[i]` is high and `out_cnt[i] < MAX_OUT`.
- Round-robin pointer `rr_ptr`:
  - Winner is the first eligible index starting at `rr_ptr`, wrapping modulo `N_REQ`.
  - On acceptance, `rr_ptr` becomes winner+1 modulo `N_REQ`.
  - With no acceptance, `rr_ptr` holds.
- Output stage is a single register, controlled by FSM `ST_EMPTY`/`ST_FULL`:
  - `ST_EMPTY`: a winner exists, so `s_sq_ready[winner]` is 1. On transfer, load data and id, then go to `ST_FULL`.
  - `ST_FULL`: `m_sq_valid` is 1. If `m_sq_ready` is high and a winner exists, reload in the same cycle and stay in `ST_FULL`. If `m_sq_ready` is high and no winner exists, go to `ST_EMPTY`. If `m_sq_ready` is low, hold.
- `s_sq_ready[i]` is combinational: high when i is the winner and (state is `ST_EMPTY` or `m_sq_ready`). At most one bit is high.
- Credit counter i:
  - +1 on acceptance from requester i.
  - −1 on `s_ack_valid` with `s_ack_id`==i.
  - Both in the same cycle: net 0.
  - ACK with count 0: count stays 0 and `err_underflow` sets.
- `nak_flag[i]` sets on a NAK for i. It clears only on reset. A NAK still returns its credit.
- Data and id are never modified. Command ordering within a requester is preserved.

## Timing
- Reset: `m_sq_valid`=0, `m_sq_data`=0, `m_sq_id`=0, `s_sq_ready`=0, all `out_cnt`=0, `nak_flag`=0, `err_underflow`=0, `rr_ptr`=0, state `ST_EMPTY`.
- Reset mid-transfer discards the held command. Its credit is not retained.
- Latency: a command accepted at cycle T appears on `m_sq_*` at T+1.
- Throughput: 1 command/cycle while `m_sq_ready` is held high.
- Credit effects are visible in eligibility the cycle after the update:
  - An ACK at T makes a blocked requester eligible at T+1.
  - A requester that reaches `MAX_OUT` at its accept in T is ineligible from T+1.
- `m_sq_valid`/`m_sq_data` are stable while `m_sq_ready` is low (AXI4-Stream rules).

## Configuration
- `RDMA_SQ_ARB_STATS_EN` defined:
  - Adds output `stat_issued` (N_REQ×32) with per-requester commands-issued counters. They wrap at 2^32, are zero on reset, and increment on the acceptance cycle.
  - Adds `stat_stall` (N_REQ×32): cycles with `s_sq_valid[i]` high and `out_cnt[i]==MAX_OUT`.
- Undefined: both ports and all their logic are absent. Arbitration behaviour is identical either way.

## Structure
- Shared package `lynxTypes`: `RDMA_REQ_BITS`, `RDMA_MAX_OUTSTANDING`, `N_REGIONS`, and a new `RDMA_ARB_CNT_BITS`=8.
- One sub-module, `rdma_rr_sel`:
  - Purely combinational rotating-priority selector.
  - Inputs: eligible vector and `rr_ptr`.
  - Outputs: one-hot grant, encoded index and `any`.
- The FSM, credit counters and stats live in `rdma_sq_arbiter`.

## Test plan
- Fairness: N_REQ=4, all four valid continuously, `m_sq_ready`=1, no credit limit reached → `m_sq_id` sequence 0,1,2,3,0,… with one command per cycle.
- Credit cap: MAX_OUT=2, only requester 1 valid, no ACKs → two commands issued, `s_sq_ready[1]`=0 afterward and `out_cnt[1]`=2. ACK id 1 at T → requester 1 issues at T+1.
- Simultaneous events: requester 2 at count 1, accept and ACK for id 2 in the same cycle → `out_cnt[2]` stays 1.
- Backpressure: `m_sq_ready`=0 for 5 cycles while full → `m_sq_data`/`m_sq_id` stable, all `s_sq_ready`=0. Releasing ready streams without loss or duplication.
- Errors: ACK id 3 with count 0 → `err_underflow`=1, `out_cnt[3]`=0. NAK id 0 → `nak_flag[0]`=1 and `out_cnt[0]` decremented.
- Reset: assert `nreset` while `ST_FULL` → next cycle `m_sq_valid`=0 and all counters 0. With `RDMA_SQ_ARB_STATS_EN`, `stat_issued` equals the per-id count of accepted commands.
